// File: rtl/seg7_pkg.sv
// Shared constants and types for the 6-digit multiplexed 7-segment scanner.
// Segment patterns are active-low, ordered {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  localparam logic [2:0] SLOT_SL = 3'd0;
  localparam logic [2:0] SLOT_SH = 3'd1;
  localparam logic [2:0] SLOT_ML = 3'd2;
  localparam logic [2:0] SLOT_MH = 3'd3;
  localparam logic [2:0] SLOT_QL = 3'd4;
  localparam logic [2:0] SLOT_QH = 3'd5;

  localparam int DP_BIT = 7;

  // One frame's worth of display data, captured on the 5->0 digit wrap.
  typedef struct packed {
    logic       colon;
    logic [1:0] qh;
    logic [3:0] ql;
    logic [2:0] mh;
    logic [3:0] ml;
    logic [2:0] sh;
    logic [3:0] sl;
  } snap_t;

endpackage

// File: rtl/seg7_scan_if.sv
// Display-side bundle of seg7_scan: time digits and controls in, scan outputs out.
// Signal names follow the board-level pin names.
interface seg7_scan_if;
  logic       EN;
  logic       COLON;
  logic [1:0] QH;
  logic [3:0] QL;
  logic [2:0] MH;
  logic [3:0] ML;
  logic [2:0] SH;
  logic [3:0] SL;
  logic [5:0] DSEL;
  logic [7:0] SEG;

  modport master (
    output EN, COLON, QH, QL, MH, ML, SH, SL,
    input  DSEL, SEG
  );

  modport slave (
    input  EN, COLON, QH, QL, MH, ML, SH, SL,
    output DSEL, SEG
  );
endinterface

// File: rtl/seg7_dec.sv
// Combinational BCD to active-low 7-segment decoder with decimal point.
// Codes above 9 render as a dash.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);

  always_comb begin
    // NOTE: seg gets a default before the case so no path can leave it unassigned (no latch).
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    if (dp) seg[DP_BIT] = 1'b0;
  end

endmodule

// File: rtl/seg7_scan.sv
// 6-digit multiplexed 7-segment scanner with per-slot blanking and frame snapshot.
// Optional build macro: LEAD_ZERO_BLANK_EN blanks a leading zero in the hours-tens slot.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST,
  seg7_scan_if.slave bus
);

  localparam int             CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  C_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  C_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] c_q, c_d;
  logic [2:0]    idx_q, idx_d;
  snap_t         snap_q, snap_d, live;
  logic [5:0]    dsel_q, dsel_d;
  logic [7:0]    seg_q, seg_d;

  logic          slot_wrap;
  logic [3:0]    digit;
  logic          dp;
  logic          lead_blank;
  logic [7:0]    dec_seg;

  assign live = '{colon: bus.COLON, qh: bus.QH, ql: bus.QL, mh: bus.MH,
                  ml: bus.ML, sh: bus.SH, sl: bus.SL};

  seg7_dec u_dec (
    .bcd (digit),
    .dp  (dp),
    .seg (dec_seg)
  );

  always_comb begin
    slot_wrap = (c_q == C_LAST);
    c_d       = slot_wrap ? '0 : c_q + 1'b1;
    idx_d     = idx_q;
    snap_d    = snap_q;
    if (slot_wrap) begin
      idx_d = (idx_q == SLOT_QH) ? SLOT_SL : idx_q + 3'd1;
      if (idx_q == SLOT_QH) snap_d = live;
    end

    // The snapshot only changes while entering slot 0's blank phase, so any
    // drive-phase edge sees snap_q equal to the frame's captured data.
    digit = 4'd0;
    case (idx_d)
      SLOT_SL: digit = snap_q.sl;
      SLOT_SH: digit = {1'b0, snap_q.sh};
      SLOT_ML: digit = snap_q.ml;
      SLOT_MH: digit = {1'b0, snap_q.mh};
      SLOT_QL: digit = snap_q.ql;
      SLOT_QH: digit = {2'b00, snap_q.qh};
      default: digit = 4'd0;
    endcase
    dp = snap_q.colon && (idx_d == SLOT_ML || idx_d == SLOT_QL);

`ifdef LEAD_ZERO_BLANK_EN
    lead_blank = (idx_d == SLOT_QH) && (snap_q.qh == 2'd0);
`else
    lead_blank = 1'b0;
`endif

    // Outputs are computed from the next-state counters so they switch on the
    // same edge that enters the new phase or slot.
    dsel_d = '0;
    seg_d  = SEG_OFF;
    if (bus.EN && (c_d >= C_BLANK)) begin
      dsel_d = 6'd1 << idx_d;
      seg_d  = lead_blank ? SEG_OFF : dec_seg;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      c_q    <= '0;
      idx_q  <= SLOT_SL;
      // NOTE: the snapshot is plain flops (not a RAM), so it is reset like the rest.
      snap_q <= '0;
      dsel_q <= '0;
      seg_q  <= SEG_OFF;
    end else begin
      c_q    <= c_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      dsel_q <= dsel_d;
      seg_q  <= seg_d;
    end
  end

  assign bus.DSEL = dsel_q;
  assign bus.SEG  = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (SCAN_DIV=4, BLANK_CYC=1): directed scenarios
// plus random traffic, checked against a cycle-count based reference model.
module tb_seg7_scan;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FRAME = 6 * SD;

  logic clk = 1'b0;
  logic rst_n;

  seg7_scan_if bus ();

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Decode table written straight from the digit/pattern list.
  localparam logic [7:0] PAT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: n = active edges since reset release; snapshot values.
  int n;
  int s_sl, s_sh, s_ml, s_mh, s_ql, s_qh;
  bit s_colon;
  bit en_at_edge;

  function automatic logic [7:0] ref_decode(int v, bit dp_on);
    logic [7:0] s;
    s = (v > 9) ? 8'hBF : PAT[v];
    if (dp_on) s = s & 8'h7F;
    return s;
  endfunction

  function automatic int cur_c();
    return n % SD;
  endfunction

  function automatic int cur_idx();
    return (n / SD) % 6;
  endfunction

  task automatic cmp(string tag, logic [7:0] obs, logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp_v);
    end
  endtask

  task automatic check_model(string tag);
    int         c, idx, d;
    logic [5:0] exp_d;
    logic [7:0] exp_s;
    c   = cur_c();
    idx = cur_idx();
    exp_d = 6'b0;
    exp_s = 8'hFF;
    if (en_at_edge && c >= BC) begin
      d = (idx == 0) ? s_sl : (idx == 1) ? s_sh : (idx == 2) ? s_ml :
          (idx == 3) ? s_mh : (idx == 4) ? s_ql : s_qh;
      exp_d = 6'(1 << idx);
      exp_s = ref_decode(d, s_colon && (idx == 2 || idx == 4));
`ifdef LEAD_ZERO_BLANK_EN
      if (idx == 5 && s_qh == 0) exp_s = 8'hFF;
`endif
    end
    cmp({tag, "_dsel"}, {2'b00, bus.DSEL}, {2'b00, exp_d});
    cmp({tag, "_seg"}, bus.SEG, exp_s);
  endtask

  task automatic model_reset();
    n = 0;
    s_sl = 0; s_sh = 0; s_ml = 0; s_mh = 0; s_ql = 0; s_qh = 0;
    s_colon = 1'b0;
    en_at_edge = 1'b1;
  endtask

  // One clock: advance model with the inputs present at the edge, then check.
  task automatic tick(string tag);
    @(posedge clk);
    n++;
    en_at_edge = bus.EN;
    if (n % FRAME == 0) begin
      s_sl = int'(bus.SL); s_sh = int'(bus.SH); s_ml = int'(bus.ML);
      s_mh = int'(bus.MH); s_ql = int'(bus.QL); s_qh = int'(bus.QH);
      s_colon = bus.COLON;
    end
    #1;
    check_model(tag);
  endtask

  // Advance until the edge that snapshots (bounded by one frame).
  task automatic run_to_snapshot(string tag);
    for (int i = 0; i < FRAME; i++) begin
      tick(tag);
      if (n % FRAME == 0) break;
    end
  endtask

  task automatic set_time(int qh, int ql, int mh, int ml, int sh, int sl, bit colon);
    bus.QH = 2'(qh); bus.QL = 4'(ql); bus.MH = 3'(mh);
    bus.ML = 4'(ml); bus.SH = 3'(sh); bus.SL = 4'(sl);
    bus.COLON = colon;
  endtask

  logic [7:0] frame_exp [6];
  logic [7:0] lz_exp;

  initial begin
    rst_n = 1'b0;
    bus.EN = 1'b1;
    set_time(0, 0, 0, 0, 0, 0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;
    check_model("release_blank");
    for (int i = 0; i < 3; i++) begin
      tick("first_slot");
      cmp("first_slot_dsel", {2'b00, bus.DSEL}, 8'h01);
      cmp("first_slot_seg", bus.SEG, 8'hC0);
    end
    tick("slot1_blank");

    // Full frame 23:59:58 with colon.
    set_time(2, 3, 5, 9, 5, 8, 1'b1);
    frame_exp = '{8'h80, 8'h92, 8'h10, 8'h92, 8'h30, 8'hA4};
    run_to_snapshot("frame_sync");
    for (int i = 0; i < FRAME; i++) begin
      tick("frame");
      if (cur_c() >= BC) cmp("frame_slot", bus.SEG, frame_exp[cur_idx()]);
    end

    // Tearing: SL changes mid-frame, slot 0 updates only after the next wrap.
    while (cur_idx() != 2) tick("tear_wait");
    bus.SL = 4'd9;
    run_to_snapshot("tear_hold");
    for (int i = 0; i < SD; i++) begin
      tick("tear_new");
      if (cur_c() >= BC) cmp("tear_slot0", bus.SEG, 8'h90);
    end

    // Invalid BCD in hours-units, with and without colon.
    bus.QL = 4'd12;
    run_to_snapshot("inv_sync");
    for (int i = 0; i < FRAME; i++) begin
      tick("inv_colon");
      if (cur_idx() == 4 && cur_c() >= BC) cmp("inv_slot4_dp", bus.SEG, 8'h3F);
    end
    bus.COLON = 1'b0;
    run_to_snapshot("inv_sync2");
    for (int i = 0; i < FRAME; i++) begin
      tick("inv_nocolon");
      if (cur_idx() == 4 && cur_c() >= BC) cmp("inv_slot4", bus.SEG, 8'hBF);
    end

    // Enable low for 5 cycles, then resume at the free-running position.
    repeat (2) tick("pre_en");
    bus.EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick("en_low");
      cmp("en_low_dsel", {2'b00, bus.DSEL}, 8'h00);
      cmp("en_low_seg", bus.SEG, 8'hFF);
    end
    bus.EN = 1'b1;
    repeat (SD * 2) tick("en_resume");

    // Leading-zero handling on hours tens.
`ifdef LEAD_ZERO_BLANK_EN
    lz_exp = 8'hFF;
`else
    lz_exp = 8'hC0;
`endif
    set_time(0, 7, 1, 2, 3, 4, 1'b0);
    run_to_snapshot("lz_sync");
    for (int i = 0; i < FRAME; i++) begin
      tick("lz_zero");
      if (cur_idx() == 5 && cur_c() >= BC) begin
        cmp("lz_slot5_zero", bus.SEG, lz_exp);
        cmp("lz_slot5_dsel", {2'b00, bus.DSEL}, 8'h20);
      end
    end
    bus.QH = 2'd1;
    run_to_snapshot("lz_sync2");
    for (int i = 0; i < FRAME; i++) begin
      tick("lz_one");
      if (cur_idx() == 5 && cur_c() >= BC) cmp("lz_slot5_one", bus.SEG, 8'hF9);
    end

    // Mid-frame asynchronous reset, in a drive phase.
    while (cur_c() < BC) tick("rst_wait");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_reset");
    @(posedge clk);
    #1;
    check_model("reset_held");
    rst_n = 1'b1;
    check_model("rerelease_blank");
    for (int i = 0; i < 3; i++) begin
      tick("rerelease_slot0");
      cmp("rerelease_seg", bus.SEG, 8'hC0);
    end

    // Random traffic, including invalid codes and enable toggling.
    for (int i = 0; i < 600; i++) begin
      bus.EN    = ($urandom_range(0, 7) != 0);
      bus.COLON = 1'($urandom);
      bus.QH    = 2'($urandom);
      bus.QL    = 4'($urandom);
      bus.MH    = 3'($urandom);
      bus.ML    = 4'($urandom);
      bus.SH    = 3'($urandom);
      bus.SL    = 4'($urandom);
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Multiplexed 6-digit 7-segment display scanner for the 24-hour clock. Reads the BCD time digits produced by the hour/minute/second counters, snapshots them once per scan frame, and time-multiplexes them onto a shared segment bus with one-hot digit enables. Sits between the counter chain and the board's display pins.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; legal range is ≥ 2.
- BLANK_CYC, 4: blanking cycles at the start of each slot (anti-ghosting); legal range is 1 ≤ BLANK_CYC < SCAN_DIV.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  display enable; when low, outputs are blanked and counters keep running.
- COLON  in  1  when high, lights the decimal point on the hours-low and minutes-low digits.
- QH  in  2  hours tens, BCD.
- QL  in  4  hours units, BCD.
- MH  in  3  minutes tens, BCD.
- ML  in  4  minutes units, BCD.
- SH  in  3  seconds tens, BCD.
- SL  in  4  seconds units, BCD.
- DSEL  out  6  one-hot digit enable, active-high; bit i drives slot i.
- SEG  out  8  segments, active-low, ordered {dp,g,f,e,d,c,b,a}.

## Operation
- Slot counter `c` runs 0..SCAN_DIV-1. Digit index `idx` runs 0..5 and advances when `c` wraps; `idx` wraps from 5 to 0.
- Slot map:
  - 0 = SL, 1 = SH, 2 = ML, 3 = MH, 4 = QL, 5 = QH.
  - The dp lights only on slots 2 and 4, and only when COLON is high.
- Snapshot:
  - On the edge where `idx` wraps 5→0, all six digits and COLON are registered.
  - Display data comes only from the snapshot, so no tearing occurs within a frame.
- Two phases per slot:
  - BLANK (c < BLANK_CYC): DSEL = 0, SEG = 8'hFF.
  - DRIVE (c ≥ BLANK_CYC): DSEL = 1<<idx, SEG = decode(digit) with dp applied.
- Decode (dp off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Any value above 9 shows '-' = BF.
  - dp on clears bit 7.
- EN low forces DSEL = 0 and SEG = FF. It does not stop `c`, `idx` or snapshotting, so re-enable resumes at the current slot and phase.
- Reset:
  - Asserting RST low mid-operation clears state immediately (asynchronously).
  - Reset values: c = 0, idx = 0, snapshot = all zero, DSEL = 6'b0, SEG = 8'hFF.

## Timing
- DSEL and SEG are registered and change on the same edge that moves `c` or `idx` into the new phase or slot. There is no extra pipeline stage.
- Frame period is 6·SCAN_DIV cycles.
- Latency from an input change to display is up to one frame plus BLANK_CYC cycles.
- Simultaneous slot wrap and snapshot: new slot 0 is in BLANK on that edge, so new data first appears BLANK_CYC cycles later.
- After reset release, the first DRIVE of slot 0 starts BLANK_CYC cycles after the first active edge and shows the reset snapshot (SL = 0 → C0).

## Configuration
- LEAD_ZERO_BLANK_EN
  - Defined: in slot 5, a snapshot QH of 0 drives SEG = FF. DSEL still follows the normal schedule.
  - Undefined: slot 5 always decodes normally, so QH = 0 shows C0.

## Structure
- Package `seg7_pkg` holds:
  - segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF);
  - slot index constants (SLOT_SL..SLOT_QH);
  - the dp bit position.
- One sub-module, `seg7_dec`: combinational 4-bit BCD plus dp in, 8-bit active-low segments out, with invalid input → dash. It is instantiated once on the selected snapshot digit.

## Test plan
All scenarios use SCAN_DIV = 4 and BLANK_CYC = 1.
- Reset: pulse RST low mid-frame → DSEL = 0 and SEG = FF immediately. After release: one blank cycle, then DSEL = 000001, SEG = C0 for 3 cycles.
- Full frame: drive 23:59:58 with COLON = 1 before a snapshot. The slots must show 80, 92, 10 (ML 9 with dp), 92, 30 (QL 3 with dp), A4. Each slot is preceded by one FF/000000 cycle.
- Tearing: change SL from 8 to 9 while idx = 2 → slot 0 keeps showing 80 until after the next 5→0 wrap, then shows 90.
- Invalid BCD: QL = 4'd12 → slot 4 shows BF, or 3F with COLON = 1.
- Enable: hold EN low for 5 cycles → DSEL = 0 and SEG = FF throughout. On return high, output matches the slot/phase implied by free-running `c`/`idx`.
- Macro: with QH = 0, slot 5 shows FF when LEAD_ZERO_BLANK_EN is defined and C0 when it is undefined. With QH = 1, slot 5 shows F9 in both builds.
